// File: rtl/pq_traffic_gen.sv
// Traffic generator for the priority-queue device port: fills the queue with LFSR keys,
// then drains it, checking min-first ordering and insert/remove count conservation.
`timescale 1ns/1ps
module pq_traffic_gen #(
   parameter int unsigned   KW      = 8,
   parameter int unsigned   VW      = 8,
   parameter int unsigned   CW      = 8,
   parameter logic [KW-1:0] TAPS    = 8'hB8,
   parameter int unsigned   TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] num_ops,
   input  logic [KW-1:0] seed,
   input  logic          busy,
   input  logic          full,
   input  logic          empty,
   input  logic [KW-1:0] kvo_key,
   input  logic [VW-1:0] kvo_val,
   output logic          ins,
   output logic          rem,
   output logic [KW-1:0] kvi_key,
   output logic [VW-1:0] kvi_val,
   output logic          done,
   output logic [7:0]    err_count,
   output logic [CW-1:0] ins_count,
   output logic [CW-1:0] rem_count,
   output logic          overflow
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StFill, StGap, StDrain, StDone} state_t;

   state_t        state_q, state_d;
   logic          gap_drain_q, gap_drain_d;  // GAP returns to DRAIN when set, else FILL
   logic [CW-1:0] n_q, n_d;
   logic [KW-1:0] lfsr_q, lfsr_d;
   logic [KW-1:0] last_q, last_d;
   logic [TW-1:0] to_q, to_d;
   logic          ins_q, ins_d, rem_q, rem_d, done_q, done_d, ovf_q, ovf_d;
   logic [KW-1:0] key_q, key_d;
   logic [VW-1:0] val_q, val_d;
   logic [7:0]    err_q, err_d, err_sat;
   logic [CW-1:0] ins_cnt_q, ins_cnt_d, rem_cnt_q, rem_cnt_d;
   logic          unused_kvo_val;

   assign unused_kvo_val = ^kvo_val;
   assign err_sat = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      gap_drain_d = gap_drain_q;
      n_d         = n_q;
      lfsr_d      = lfsr_q;
      last_d      = last_q;
      to_d        = to_q;
      ins_d       = 1'b0;
      rem_d       = 1'b0;
      done_d      = done_q;
      ovf_d       = ovf_q;
      key_d       = key_q;
      val_d       = val_q;
      err_d       = err_q;
      ins_cnt_d   = ins_cnt_q;
      rem_cnt_d   = rem_cnt_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               n_d       = num_ops;
               lfsr_d    = (seed == '0) ? KW'(1) : seed;
               ins_cnt_d = '0;
               rem_cnt_d = '0;
               err_d     = '0;
               ovf_d     = 1'b0;
               to_d      = '0;
               if (num_ops != '0) begin
                  done_d  = 1'b0;
                  state_d = StFill;
               end else begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StFill: begin
            if (!busy) to_d = '0;
            if (ins_cnt_q == n_q) begin
               state_d = StDrain;
            end else if (full) begin
               ovf_d   = 1'b1;
               state_d = StDrain;
            end else if (!busy) begin
               ins_d       = 1'b1;
               key_d       = lfsr_q;
               val_d       = VW'(ins_cnt_q);
               ins_cnt_d   = ins_cnt_q + CW'(1);
               lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
               gap_drain_d = 1'b0;
               state_d     = StGap;
            end else if (to_q == TW'(TIMEOUT - 1)) begin
               err_d   = err_sat;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               to_d = to_q + TW'(1);
            end
         end
         StGap: begin
            state_d = gap_drain_q ? StDrain : StFill;
         end
         StDrain: begin
            if (!busy) begin
               to_d = '0;
               if (!empty) begin
                  rem_d  = 1'b1;
                  last_d = kvo_key;
                  // The first pop has no predecessor to compare against.
                  if ((rem_cnt_q != '0) && (kvo_key < last_q)) err_d = err_sat;
                  rem_cnt_d   = rem_cnt_q + CW'(1);
                  gap_drain_d = 1'b1;
                  state_d     = StGap;
               end else begin
                  if (rem_cnt_q != ins_cnt_q) err_d = err_sat;
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end else if (to_q == TW'(TIMEOUT - 1)) begin
               err_d   = err_sat;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               to_d = to_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         gap_drain_q <= 1'b0;
         n_q         <= '0;
         lfsr_q      <= KW'(1);
         last_q      <= '0;
         to_q        <= '0;
         ins_q       <= 1'b0;
         rem_q       <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         key_q       <= '0;
         val_q       <= '0;
         err_q       <= '0;
         ins_cnt_q   <= '0;
         rem_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         gap_drain_q <= gap_drain_d;
         n_q         <= n_d;
         lfsr_q      <= lfsr_d;
         last_q      <= last_d;
         to_q        <= to_d;
         ins_q       <= ins_d;
         rem_q       <= rem_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         key_q       <= key_d;
         val_q       <= val_d;
         err_q       <= err_d;
         ins_cnt_q   <= ins_cnt_d;
         rem_cnt_q   <= rem_cnt_d;
      end
   end

   assign ins       = ins_q;
   assign rem       = rem_q;
   assign kvi_key   = key_q;
   assign kvi_val   = val_q;
   assign done      = done_q;
   assign err_count = err_q;
   assign ins_count = ins_cnt_q;
   assign rem_count = rem_cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pq_traffic_gen.sv
// Bench for pq_traffic_gen: a queue-based priority-queue model answers the generator,
// directed scenarios plus randomized runs are checked against expected outcomes.
`timescale 1ns/1ps
module tb_pq_traffic_gen;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] num_ops, seed;
   logic       busy, full, empty;
   logic [7:0] kvo_key, kvo_val;
   logic       ins, rem, done, overflow;
   logic [7:0] kvi_key, kvi_val, err_count, ins_count, rem_count;

   pq_traffic_gen dut (
      .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .seed(seed),
      .busy(busy), .full(full), .empty(empty), .kvo_key(kvo_key), .kvo_val(kvo_val),
      .ins(ins), .rem(rem), .kvi_key(kvi_key), .kvi_val(kvi_val), .done(done),
      .err_count(err_count), .ins_count(ins_count), .rem_count(rem_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   logic [7:0] pq[$];
   logic [7:0] ins_log[$];
   logic [7:0] pop_log[$];
   int   depth  = 16;
   int   bmode  = 0;  // 0: never busy, 1: random busy, 2: stuck busy
   bit   faulty = 0;  // FIFO order instead of min-first
   bit   prev_op = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      empty   = (pq.size() == 0);
      full    = (pq.size() >= depth);
      kvo_key = empty ? 8'h00 : pq[0];
      kvo_val = ~kvo_key;
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
   endfunction

   // Device model: acts on the pulse visible at each falling edge.
   always @(negedge clk) begin
      if (ins || rem) check("protocol", {29'd0, ins & rem, busy, prev_op}, 32'd0);
      prev_op = ins || rem;
      if (ins) begin
         int i;
         check("kvi_val", kvi_val, ins_log.size());
         ins_log.push_back(kvi_key);
         i = 0;
         if (faulty) i = pq.size();
         else while (i < pq.size() && pq[i] <= kvi_key) i++;
         pq.insert(i, kvi_key);
      end
      if (rem && pq.size() > 0) begin
         pop_log.push_back(pq[0]);
         void'(pq.pop_front());
      end
      refresh();
      if (bmode == 1) busy = ($urandom_range(3) == 0);
      else busy = (bmode == 2);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic go(input logic [7:0] n, input logic [7:0] s);
      num_ops = n;
      seed    = s;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int i = 0;
      while (!done && i < budget) begin
         step();
         i++;
      end
      check(tag, done, 1);
   endtask

   task automatic clear_model();
      pq.delete();
      ins_log.delete();
      pop_log.delete();
      refresh();
   endtask

   // Compares the insert stream with the LFSR rule and the pops with sorted inserts.
   task automatic check_streams(input logic [7:0] s, input int k);
      logic [7:0] x, srt[$];
      int bad = 0;
      x = (s == 0) ? 8'h01 : s;
      for (int i = 0; i < k; i++) begin
         if (i >= ins_log.size() || ins_log[i] !== x) bad++;
         x = lfsr_next(x);
      end
      check("key_stream", bad, 0);
      srt = ins_log;
      srt.sort();
      bad = (srt.size() == pop_log.size()) ? 0 : 1;
      for (int i = 0; i < srt.size() && i < pop_log.size(); i++)
         if (srt[i] !== pop_log[i]) bad++;
      check("pop_order", bad, 0);
   endtask

   initial begin
      logic [7:0] ek[4];
      logic [7:0] ep[4];
      logic [7:0] frozen, n, s;
      int i, exp_ins;

      rst = 1'b1; start = 1'b0; num_ops = '0; seed = '0; busy = 1'b0;
      refresh();
      repeat (3) step();
      check("rst_ins", ins, 0);
      check("rst_rem", rem, 0);
      check("rst_done", done, 0);
      check("rst_err", err_count, 0);
      check("rst_cnts", {ins_count, rem_count}, 0);
      check("rst_ovf", overflow, 0);
      check("rst_kvi", {kvi_key, kvi_val}, 0);
      rst = 1'b0;
      step();

      // Ideal queue, seed 1, four ops.
      ek = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
      ep = '{8'h01, 8'h2E, 8'h5C, 8'hB8};
      clear_model();
      go(8'd4, 8'h01);
      wait_done(200, "ideal_done");
      check("ideal_ins", ins_count, 4);
      check("ideal_rem", rem_count, 4);
      check("ideal_err", err_count, 0);
      check("ideal_ovf", overflow, 0);
      check("ideal_nins", ins_log.size(), 4);
      check("ideal_npop", pop_log.size(), 4);
      for (int k = 0; k < 4 && k < ins_log.size(); k++) check("ideal_key", ins_log[k], ek[k]);
      for (int k = 0; k < 4 && k < pop_log.size(); k++) check("ideal_pop", pop_log[k], ep[k]);

      // Faulty queue returning insert order.
      clear_model();
      faulty = 1;
      go(8'd4, 8'h01);
      wait_done(200, "faulty_done");
      check("faulty_err", err_count, 2);
      check("faulty_rem", rem_count, 4);
      faulty = 0;

      // Depth 3, five ops requested.
      clear_model();
      depth = 3;
      refresh();
      go(8'd5, 8'h77);
      wait_done(200, "ovf_done");
      check("ovf_flag", overflow, 1);
      check("ovf_ins", ins_count, 3);
      check("ovf_rem", rem_count, 3);
      check("ovf_err", err_count, 0);
      depth = 16;

      // Busy stuck high during FILL.
      clear_model();
      go(8'd10, 8'h5A);
      i = 0;
      while (ins_count != 8'd2 && i < 50) begin
         step();
         i++;
      end
      check("to_reach2", ins_count, 2);
      bmode  = 2;
      busy   = 1'b1;
      frozen = ins_count;
      repeat (63) step();
      check("to_early", done, 0);
      wait_done(4, "to_done");
      check("to_err", err_count, 1);
      check("to_frozen", ins_count, frozen);
      check("to_rem", rem_count, 0);
      bmode = 0;
      busy  = 1'b0;
      step();

      // Zero-length run.
      clear_model();
      go(8'd0, 8'h33);
      check("zero_done", done, 1);
      check("zero_err", err_count, 0);
      repeat (3) step();
      check("zero_ops", ins_log.size() + pop_log.size(), 0);
      check("zero_cnts", {ins_count, rem_count}, 0);

      // Reset in the middle of DRAIN.
      clear_model();
      bmode = 1;
      go(8'd6, 8'($urandom));
      i = 0;
      while (rem_count < 8'd2 && i < 300) begin
         step();
         i++;
      end
      check("mid_reach", rem_count >= 8'd2, 1);
      rst = 1'b1;
      step();
      check("mid_rst_ops", {ins, rem}, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_cnts", {err_count, ins_count, rem_count}, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_kvi", {kvi_key, kvi_val}, 0);
      rst   = 1'b0;
      bmode = 0;
      busy  = 1'b0;
      step();
      clear_model();
      go(8'd5, 8'hC3);
      wait_done(200, "post_done");
      check("post_err", err_count, 0);
      check("post_cnts", {ins_count, rem_count}, {8'd5, 8'd5});
      check_streams(8'hC3, 5);

      // Randomized runs with random busy and depth.
      for (int r = 0; r < 10; r++) begin
         n     = 8'($urandom_range(14, 1));
         s     = 8'($urandom);
         depth = $urandom_range(16, 2);
         bmode = 1;
         clear_model();
         go(n, s);
         wait_done(2000, "rnd_done");
         exp_ins = (n < depth) ? n : depth;
         check("rnd_ins", ins_count, exp_ins);
         check("rnd_rem", rem_count, exp_ins);
         check("rnd_err", err_count, 0);
         check("rnd_ovf", overflow, (n > depth) ? 1 : 0);
         check_streams(s, exp_ins);
      end
      bmode = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
